inv_rotate_top: RTL and testbench
=================================

INV_ROTATE_TOP -- requirements
Module: inv_rotate_top

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 inv_rotate_en  input  1  start request, level-sampled in IDLE.
REQ-005 line_in  input  25  slice read data, combinational from external memory at cnt_value, same cycle.
REQ-006 cnt_value  output  6  slice index, used as read address in LOAD and as write index in WRITE.
REQ-007 write_enable  output  1  registered, one-cycle pulse per output slice.
REQ-008 write_value  output  25  registered, de-rotated slice for index cnt_value.
REQ-009 done  output  1  registered, one-cycle completion pulse.

Function
REQ-010 State layout: 64 slices z=0..63 of 25 bits; bit k of a slice = lane k = 5*y+x, LSB = bit 0.
REQ-011 Offsets r[k], k=0..24, fixed constants: 0,1,62,28,27, 36,44,6,55,20, 3,10,43,25,39, 41,45,15,21,8, 18,2,61,56,14.
REQ-012 Output bit k of slice z SHALL equal input bit k of slice (z + r[k]) mod 64, the exact inverse of rotate_top's lane rotation.
REQ-013 Internal buffer: 64 x 25 bits, fully loaded before any write.
REQ-014 FSM states: IDLE, LOAD, WRITE, DONE, WAIT_LOW.
REQ-015 IDLE: cnt_value=0, outputs low; on edge E0 with inv_rotate_en=1 -> LOAD.
REQ-016 LOAD: at edges E1..E64, buf[cnt_value] <= line_in, cnt_value increments; E64 wraps cnt_value to 0 and enters WRITE.
REQ-017 WRITE: two cycles per slice z=0..63; write_enable=1 in the first cycle (after edge E64+2z), 0 in the second (after E65+2z).
REQ-018 In WRITE, cnt_value=z and write_value=de-rotated slice z, both stable across both cycles of that slice.
REQ-019 Exactly 64 write_enable rising edges per operation.
REQ-020 Edge E192 -> DONE, done=1 for exactly one cycle; E193 -> WAIT_LOW.
REQ-021 WAIT_LOW: stays until inv_rotate_en=0, then IDLE; no re-run while inv_rotate_en is held high.
REQ-022 inv_rotate_en deasserted during LOAD/WRITE SHALL be ignored; operation completes.
REQ-023 write_value SHALL be 0 outside WRITE; cnt_value SHALL be 0 in IDLE, DONE and WAIT_LOW.
REQ-024 Modular index arithmetic SHALL use 6-bit wrap (z+r truncated to 6 bits).

Reset
REQ-025 rst=1 SHALL immediately force IDLE, cnt_value=0, write_enable=0, write_value=0, done=0, regardless of state.
REQ-026 Buffer contents need not be cleared; a new operation fully reloads it.
REQ-027 Reset mid-operation SHALL abort with no further writes; the next start runs a complete 64-slice operation.

Verification
REQ-028 Reset check: rst pulse at any state -> all outputs 0 within the same cycle, FSM in IDLE.
REQ-029 All-zero memory, start -> 64 write_enable pulses, all write_value=0, done high one cycle after E192.
REQ-030 mem[0]=25'h0000002 (lane 1, r=1) -> only output slice 63 = 25'h0000002; all others 0.
REQ-031 mem[5]=25'h0000004 (lane 2, r=62) -> only output slice 7 = 25'h0000004; all others 0.
REQ-032 Round trip: random 64-slice input through rotate_top, its output loaded here -> 64 outputs equal the original input bit-exactly.
REQ-033 rst asserted at WRITE z=20, then released and started -> no writes during abort; restart yields 64 correct writes; inv_rotate_en held high after done -> no second run.

Source files
------------

// File: rtl/inv_rotate_top.sv
// inv_rotate_top: undoes the per-lane rotation of a 64x25 slice state.
// Loads 64 slices from memory, then writes each de-rotated slice back.
//   clk, rst          : clock, async active-high reset
//   inv_rotate_en     : start request (level, sampled in IDLE)
//   line_in[24:0]     : read data for slice cnt_value (same cycle)
//   cnt_value[5:0]    : read address in LOAD, write index in WRITE
//   write_enable      : one-cycle pulse per output slice
//   write_value[24:0] : de-rotated slice for cnt_value
//   done              : one-cycle completion pulse
module inv_rotate_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv_rotate_en,
  input  logic [24:0] line_in,
  output logic [5:0]  cnt_value,
  output logic        write_enable,
  output logic [24:0] write_value,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  localparam logic [5:0] ROT [25] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic        r_ph;
  logic        r_we;
  logic [24:0] r_wv;
  logic        r_done;
  logic [24:0] r_buf [64];

  logic [5:0]  w_zn;
  logic [24:0] w_derot;

  // Slice about to be presented: 0 when leaving LOAD, else cnt+1.
  // Leaving LOAD, slot 63 is still being written, but slice 0
  // never reads it (no offset equals 63).
  always_comb begin
    w_zn    = (r_state == S_WRITE) ? r_cnt + 6'd1 : 6'd0;
    w_derot = '0;
    for (int k = 0; k < 25; k++) begin
      w_derot[k] = r_buf[6'(w_zn + ROT[k])][k];
    end
  end

  // Buffer is not reset; every run reloads all 64 slots.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_buf[r_cnt] <= line_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ph    <= 1'b0;
      r_we    <= 1'b0;
      r_wv    <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_we   <= 1'b0;
          r_wv   <= '0;
          r_done <= 1'b0;
          if (inv_rotate_en) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state <= S_WRITE;
            r_ph    <= 1'b0;
            r_we    <= 1'b1;
            r_wv    <= w_derot;
          end
        end
        S_WRITE: begin
          if (!r_ph) begin
            r_ph <= 1'b1;
            r_we <= 1'b0;
          end else if (r_cnt == 6'd63) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_wv    <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            r_ph  <= 1'b0;
            r_we  <= 1'b1;
            r_wv  <= w_derot;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!inv_rotate_en) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_we    <= 1'b0;
          r_wv    <= '0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_value    = r_cnt;
  assign write_enable = r_we;
  assign write_value  = r_wv;
  assign done         = r_done;

endmodule

// File: tb/tb_inv_rotate_top.sv
// tb_inv_rotate_top: scoreboard bench for inv_rotate_top.
// Expected slices are queued at start and popped on write_enable.
module tb_inv_rotate_top;

  logic        clk;
  logic        rst;
  logic        inv_rotate_en;
  logic [24:0] line_in;
  logic [5:0]  cnt_value;
  logic        write_enable;
  logic [24:0] write_value;
  logic        done;

  inv_rotate_top dut (
    .clk          (clk),
    .rst          (rst),
    .inv_rotate_en(inv_rotate_en),
    .line_in      (line_in),
    .cnt_value    (cnt_value),
    .write_enable (write_enable),
    .write_value  (write_value),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  z;
    logic [24:0] v;
  } ent_t;

  int ROT [25] = '{
    0, 1, 62, 28, 27, 36, 44, 6, 55, 20,
    3, 10, 43, 25, 39, 41, 45, 15, 21, 8,
    18, 2, 61, 56, 14
  };

  logic [24:0] mem [64];
  logic [24:0] ex  [64];
  logic [24:0] xs  [64];
  ent_t        q   [$];

  int n_tot = 0;
  int n_bad = 0;
  int n_we = 0;
  int n_done = 0;

  assign line_in = mem[cnt_value];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  logic        p_we = 1'b0;
  logic [24:0] p_wv;
  logic [5:0]  p_cnt;
  ent_t        e;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      n_we++;
      if (q.size() == 0) begin
        chk("extra_wr", 1, 0);
      end else begin
        e = q.pop_front();
        chk("wr_idx", 32'(cnt_value), 32'(e.z));
        chk("wr_val", 32'(write_value), 32'(e.v));
      end
    end else if (p_we && !rst) begin
      chk("hold_idx", 32'(cnt_value), 32'(p_cnt));
      chk("hold_val", 32'(write_value), 32'(p_wv));
    end
    if (done === 1'b1) begin
      n_done++;
      chk("done_wv", 32'(write_value), 0);
      chk("done_cnt", 32'(cnt_value), 0);
    end
    p_we  = (write_enable === 1'b1);
    p_wv  = write_value;
    p_cnt = cnt_value;
  end

  function automatic void clr_mem();
    for (int z = 0; z < 64; z++) begin
      mem[z] = '0;
      ex[z]  = '0;
    end
  endfunction

  // Forward lane rotation into mem; the original is the expectation.
  function automatic void fwd_rand();
    for (int z = 0; z < 64; z++) begin
      xs[z] = 25'($urandom);
    end
    for (int z = 0; z < 64; z++) begin
      for (int k = 0; k < 25; k++) begin
        mem[z][k] = xs[(z - ROT[k]) & 63][k];
      end
      ex[z] = xs[z];
    end
  endfunction

  function automatic void push_exp();
    for (int z = 0; z < 64; z++) begin
      q.push_back('{z: 6'(z), v: ex[z]});
    end
  endfunction

  task automatic run_op(input bit hold);
    int n;
    int we0;
    bit seen;
    we0  = n_we;
    seen = 0;
    n    = 0;
    push_exp();
    @(negedge clk);
    inv_rotate_en = 1'b1;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      if (!hold && n == 5) inv_rotate_en = 1'b0;
    end
    chk("done_seen", 32'(seen), 1);
    chk("done_lat", n, 193);
    @(negedge clk);
    chk("done_1cyc", 32'(done), 0);
    chk("n_writes", n_we - we0, 64);
    chk("q_empty", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cnt"}, 32'(cnt_value), 0);
    chk({tag, "_we"}, 32'(write_enable), 0);
    chk({tag, "_wv"}, 32'(write_value), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    int we1;
    int d1;
    int n;
    bit hit;
    rst = 1'b1;
    inv_rotate_en = 1'b0;
    clr_mem();
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("idle");

    // All-zero memory.
    clr_mem();
    run_op(0);

    // Lane 1 in slice 0 lands in output slice 63.
    clr_mem();
    mem[0] = 25'h0000002;
    ex[63] = 25'h0000002;
    run_op(0);

    // Lane 2 in slice 5 lands in output slice 7.
    clr_mem();
    mem[5] = 25'h0000004;
    ex[7]  = 25'h0000004;
    run_op(0);

    // Round trip through the forward rotation.
    fwd_rand();
    run_op(0);
    repeat (3) @(negedge clk);

    // Abort at WRITE slice 20.
    fwd_rand();
    push_exp();
    @(negedge clk);
    inv_rotate_en = 1'b1;
    hit = 0;
    n = 0;
    while (!hit && n < 400) begin
      @(negedge clk);
      n++;
      if (write_enable === 1'b1 && cnt_value == 6'd20) hit = 1;
    end
    chk("abort_reach", 32'(hit), 1);
    inv_rotate_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    q.delete();
    we1 = n_we;
    repeat (5) @(negedge clk);
    chk("abort_nowr", n_we - we1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("post_abort");

    // Restart with en held high afterwards: no second run.
    fwd_rand();
    run_op(1);
    we1 = n_we;
    d1  = n_done;
    repeat (300) @(negedge clk);
    chk("no_rerun_we", n_we - we1, 0);
    chk("no_rerun_done", n_done - d1, 0);
    chk_zero("wait_low");
    inv_rotate_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("final");

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
